six_bits_four_inputs_sub: RTL and testbench

SIX_BITS_FOUR_INPUTS_SUB -- requirements
Module: six_bits_four_inputs_sub

---
 rtl/six_bits_four_inputs_sub.sv | 152 +++++++++++++++
 tb/tb_six_bits_four_inputs_sub.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/six_bits_four_inputs_sub.sv
// Sequential a-b-c-d subtractor: one borrow-lookahead subtraction per cycle, valid/ready handshakes.
// Define SIX_BITS_SUB_SAT_EN to clamp negative results to zero and raise udf.
module six_bits_four_inputs_sub (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic [5:0] c,
    input  logic [5:0] d,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] diff,
    output logic       udf
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SUB_B = 3'd1,
        SUB_C = 3'd2,
        SUB_D = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Returns x - y using generate = ~x&y, propagate = ~(x^y) and borrow-in 0.
    function automatic logic [8:0] bla_sub(input logic [8:0] x, input logic [8:0] y);
        logic [8:0] g;
        logic [8:0] p;
        logic [9:0] bw;
        g     = ~x & y;
        p     = ~(x ^ y);
        bw    = 10'd0;
        for (int i = 0; i < 9; i++) begin
            bw[i+1] = g[i] | (p[i] & bw[i]);
        end
        return x ^ y ^ bw[8:0];
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [8:0] acc_r;
    logic [5:0] b_r;
    logic [5:0] c_r;
    logic [5:0] d_r;
    logic       in_ready_r;
    logic       out_valid_r;
    logic [8:0] diff_r;
    logic       udf_r;
    logic [8:0] sub_operand_s;
    logic [8:0] sub_result_s;
    logic [8:0] diff_next_s;
    logic       udf_next_s;

    // Selects the subtrahend for the current step and computes acc minus it.
    always_comb begin
        sub_operand_s = 9'h000;
        case (state_r)
            SUB_B:   sub_operand_s = {3'b000, b_r};
            SUB_C:   sub_operand_s = {3'b000, c_r};
            SUB_D:   sub_operand_s = {3'b000, d_r};
            default: sub_operand_s = 9'h000;
        endcase
        sub_result_s = bla_sub(acc_r, sub_operand_s);
    end

    // Maps the final subtraction result onto the diff/udf outputs.
    always_comb begin
        diff_next_s = 9'h000;
        udf_next_s  = 1'b0;
`ifdef SIX_BITS_SUB_SAT_EN
        if (sub_result_s[8]) begin
            diff_next_s = 9'h000;
            udf_next_s  = 1'b1;
        end else begin
            diff_next_s = sub_result_s;
            udf_next_s  = 1'b0;
        end
`else
        diff_next_s = sub_result_s;
        udf_next_s  = 1'b0;
`endif
    end

    // Next-state logic; retiring a result always passes through IDLE before the next accept.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_next_s = SUB_B;
                else          state_next_s = IDLE;
            end
            SUB_B:   state_next_s = SUB_C;
            SUB_C:   state_next_s = SUB_D;
            SUB_D:   state_next_s = DONE;
            DONE: begin
                if (out_ready) state_next_s = IDLE;
                else           state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register with registered handshake flags decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Operand capture, accumulator stepping and result load on the last subtraction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= 9'h000;
            b_r    <= 6'd0;
            c_r    <= 6'd0;
            d_r    <= 6'd0;
            diff_r <= 9'h000;
            udf_r  <= 1'b0;
        end else begin
            if (state_r == IDLE && in_valid) begin
                acc_r <= {3'b000, a};
                b_r   <= b;
                c_r   <= c;
                d_r   <= d;
            end else if (state_r == SUB_B || state_r == SUB_C || state_r == SUB_D) begin
                acc_r <= sub_result_s;
            end else begin
                acc_r <= acc_r;
            end
            if (state_r == SUB_D) begin
                diff_r <= diff_next_s;
                udf_r  <= udf_next_s;
            end else begin
                diff_r <= diff_r;
                udf_r  <= udf_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign udf       = udf_r;

endmodule

// File: tb/tb_six_bits_four_inputs_sub.sv
// Self-checking bench for six_bits_four_inputs_sub: directed vector table, random operations
// against an integer-arithmetic model, back-pressure, and mid-operation reset.
module tb_six_bits_four_inputs_sub;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] a, b, c, d;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] diff;
    logic       udf;

    int total = 0;
    int bad   = 0;

    six_bits_four_inputs_sub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .udf       (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a, b, c, d;
        logic [8:0] diff;
        logic       udf;
        int         hold;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer a-b-c-d, then the build's output rule.
    task automatic model(input logic [5:0] va, vb, vc, vd, output logic [8:0] ed, output logic eu);
        int r;
        logic [31:0] rv;
        r  = int'(va) - int'(vb) - int'(vc) - int'(vd);
        rv = r;
`ifdef SIX_BITS_SUB_SAT_EN
        ed = (r < 0) ? 9'h000 : rv[8:0];
        eu = (r < 0) ? 1'b1 : 1'b0;
`else
        ed = rv[8:0];
        eu = 1'b0;
`endif
    endtask

    // One full operation: accept, latency, optional back-pressure, retire.
    task automatic do_op(input logic [5:0] va, vb, vc, vd, input logic [8:0] ed,
                         input logic eu, input int hold);
        int n;
        @(negedge clk);
        a = va; b = vb; c = vc; d = vd;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check("ready_before_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 6'($urandom); b = 6'($urandom); c = 6'($urandom); d = 6'($urandom);
        check("busy_after_accept", in_ready, 0);
        n = 0;
        while (!out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 3);
        check("diff", diff, ed);
        check("udf", udf, eu);
        in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            a = 6'($urandom); b = 6'($urandom);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_diff", diff, ed);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("retire_ready", in_ready, 1);
        check("retire_valid", out_valid, 0);
        check("idle_diff_held", diff, ed);
    endtask

    initial begin
        logic [8:0] ed;
        logic       eu;
        int         seen;

        vecs[0] = '{6'd63, 6'd1,  6'd2,  6'd3,  9'h039, 1'b0, 0};
`ifdef SIX_BITS_SUB_SAT_EN
        vecs[1] = '{6'd0,  6'd63, 6'd63, 6'd63, 9'h000, 1'b1, 0};
`else
        vecs[1] = '{6'd0,  6'd63, 6'd63, 6'd63, 9'h143, 1'b0, 0};
`endif
        vecs[2] = '{6'd10, 6'd10, 6'd0,  6'd0,  9'h000, 1'b0, 1};
        vecs[3] = '{6'd40, 6'd5,  6'd7,  6'd9,  9'h013, 1'b0, 2};
        vecs[4] = '{6'd63, 6'd1,  6'd2,  6'd3,  9'h039, 1'b0, 5};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 6'd0; b = 6'd0; c = 6'd0; d = 6'd0;
        #12;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_udf", udf, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].diff, vecs[i].udf, vecs[i].hold);

        for (int i = 0; i < 30; i++) begin
            logic [5:0] ra, rb, rc, rd;
            ra = 6'($urandom); rb = 6'($urandom); rc = 6'($urandom); rd = 6'($urandom);
            model(ra, rb, rc, rd, ed, eu);
            do_op(ra, rb, rc, rd, ed, eu, $urandom_range(0, 3));
        end

        // Abort in SUB_C: reset acts at once and no result appears afterwards.
        @(negedge clk);
        a = 6'd50; b = 6'd1; c = 6'd1; d = 6'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_diff", diff, 0);
        check("abort_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        check("abort_idle", in_ready, 1);

        model(6'd33, 6'd20, 6'd20, 6'd0, ed, eu);
        do_op(6'd33, 6'd20, 6'd20, 6'd0, ed, eu, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
